branch_resolution_unit: RTL and testbench
=========================================

// Module: branch_resolution_unit
// PURPOSE
//  Producer side of the predictor update interface (predictAddr/updateAddr/branchTaken/update).
//  - Records every branch prediction issued at fetch in an in-order in-flight queue.
//  - When EX resolves the oldest branch, emits a one-cycle update to the branch predictor.
//  - Flags mispredicts for the pipeline flush logic and keeps performance counters.
// PARAMETERS
//  ADDR_WIDTH   6   predictor index width; must match the predictor's ADDR_WIDTH
//  DEPTH        4   in-flight queue entries; power of two, >= 2
//  COUNT_WIDTH  16  width of both performance counters
// PORTS
//  clk              in   1            clock, rising edge
//  rst              in   1            asynchronous, active-low reset
//  predictValid     in   1            fetch issued a branch this cycle
//  predictAddr      in   ADDR_WIDTH   predictor index used for that branch
//  prediction       in   1            direction the predictor returned (1 = taken)
//  full             out  1            queue full; fetch must stall branch issue
//  occupancy        out  clog2(DEPTH)+1  entries currently queued
//  resolveValid     in   1            EX resolved the oldest outstanding branch
//  resolveTaken     in   1            actual outcome (1 = taken)
//  update           out  1            one-cycle pulse to the predictor update port
//  updateAddr       out  ADDR_WIDTH   index to train
//  branchTaken      out  1            outcome to train with
//  mispredict       out  1            one-cycle pulse, coincident with update
//  underflow        out  1            sticky: resolve arrived with the queue empty
//  branchCount      out  COUNT_WIDTH  resolved branches, saturating
//  mispredictCount  out  COUNT_WIDTH  mispredicted branches, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): queue empty, pointers 0, every output 0 (full=0, occupancy=0).
//  - Push: predictValid && !full && !flushNow.
//    - Writes {predictAddr, prediction} at the tail.
//    - full gates a push even when a pop happens in the same cycle.
//  - Pop: resolveValid && occupancy != 0 removes the head entry.
//    - flushNow = pop && (head.pred != resolveTaken).
//  - Outputs are registered, latency 1: on the edge after a pop,
//    - update = 1, updateAddr = head.addr, branchTaken = resolveTaken, mispredict = flushNow.
//    - Otherwise update and mispredict are 0; updateAddr and branchTaken hold their last values.
//  - Mispredict flush (flushNow=1): on the same edge the queue is cleared.
//    - Head and all younger entries are discarded; rd_ptr = wr_ptr = 0, occupancy = 0.
//    - A push in that cycle is dropped as wrong-path.
//  - Simultaneous push and pop with no mispredict: occupancy unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH.
//    - occupancy ranges over 0..DEPTH.
//    - full = (occupancy == DEPTH), empty = (occupancy == 0); both are derived from occupancy.
//  - Resolve while empty: no update, no counter change; underflow sets to 1 and holds until reset.
//  - Counters:
//    - branchCount += 1 on every pop.
//    - mispredictCount += 1 on every flushNow.
//    - Both saturate at all-ones and never wrap.
//  - Reset mid-operation discards all entries and any pending update pulse asynchronously.
// STRUCTURE
//  - Shared package/header branch_defs:
//    - ENTRY_W = ADDR_WIDTH + 1
//    - field offsets ENTRY_PRED = 0, ENTRY_ADDR = 1
//    - these are shared with the predictor wrapper.
//  - Sub-module branch_fifo holds the queue storage:
//    - synchronous FIFO with push, pop and a flush input that has priority over push.
//    - reports occupancy and full.
//  - Top level holds the compare logic, output registers, sticky flag and counters.
// TESTING
//  1. Reset, then push addr 5 pred 1; resolve taken -> next cycle update=1, updateAddr=5,
//     branchTaken=1, mispredict=0, branchCount=1.
//  2. Push addr 3/pred 0, 7/pred 1, 9/pred 1; resolve taken on the head
//     -> mispredict=1, updateAddr=3, occupancy=0 the cycle after, mispredictCount=1.
//  3. Fill DEPTH=4 entries -> full=1; push with pop in the same cycle -> push dropped, occupancy=3.
//  4. Resolve with the queue empty -> update=0, underflow=1; it stays 1 through 10 further cycles.
//  5. 8 push/resolve pairs cycling through all indices -> pointer wrap correct,
//     updateAddr sequence equals the push sequence.
//  6. COUNT_WIDTH=4, 20 mispredicts -> mispredictCount holds at 15.
//     Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_defs.sv
// rtl/branch_defs.sv - shared branch queue entry layout
package branch_defs;

    // Bit offsets of the fields inside one queue entry {addr, pred}
    localparam int ENTRY_PRED = 0;
    localparam int ENTRY_ADDR = 1;

    // Entry width is the predictor index plus one prediction bit
    function automatic int entry_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// rtl/branch_fifo.sv - in-order in-flight branch queue with flush
module branch_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop frees a slot this cycle; flush drops the push
    assign do_push = push_i && (occ_q != OCC_FULL) && !flush_i;
    assign do_pop  = pop_i && (occ_q != '0);

    // Next-state for pointers and occupancy; flush wins over everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage; contents are only meaningful while counted by occupancy
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OCC_FULL);

endmodule

// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - predictor update producer with mispredict flush and counters
module branch_resolution_unit
    import branch_defs::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     predictValid_i,
    input  logic [ADDR_WIDTH-1:0]    predictAddr_i,
    input  logic                     prediction_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    input  logic                     resolveValid_i,
    input  logic                     resolveTaken_i,
    output logic                     update_o,
    output logic [ADDR_WIDTH-1:0]    updateAddr_o,
    output logic                     branchTaken_o,
    output logic                     mispredict_o,
    output logic                     underflow_o,
    output logic [COUNT_WIDTH-1:0]   branchCount_o,
    output logic [COUNT_WIDTH-1:0]   mispredictCount_o
);

    localparam int ENTRY_W = entry_w(ADDR_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [ENTRY_W-1:0]    head;
    logic [ENTRY_W-1:0]    wentry;
    logic                  empty;
    logic                  pop;
    logic                  flush_now;
    logic                  head_pred;
    logic [ADDR_WIDTH-1:0] head_addr;

    logic                   update_q;
    logic [ADDR_WIDTH-1:0]  update_addr_q;
    logic                   branch_taken_q;
    logic                   mispredict_q;
    logic                   underflow_q;
    logic [COUNT_WIDTH-1:0] branch_cnt_q;
    logic [COUNT_WIDTH-1:0] mispredict_cnt_q;

    assign wentry    = {predictAddr_i, prediction_i};
    assign head_pred = head[ENTRY_PRED];
    assign head_addr = head[ENTRY_ADDR +: ADDR_WIDTH];
    assign empty     = (occupancy_o == '0);
    assign pop       = resolveValid_i && !empty;
    assign flush_now = pop && (head_pred != resolveTaken_i);

    branch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (predictValid_i),
        .wdata_i     (wentry),
        .pop_i       (pop),
        .flush_i     (flush_now),
        .rdata_o     (head),
        .occupancy_o (occupancy_o),
        .full_o      (full_o)
    );

    // Predictor update outputs: pulse on the edge after a pop, address/outcome hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_q       <= 1'b0;
            update_addr_q  <= '0;
            branch_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
        end else begin
            update_q     <= pop;
            mispredict_q <= flush_now;
            if (pop) begin
                update_addr_q  <= head_addr;
                branch_taken_q <= resolveTaken_i;
            end
        end
    end

    // Sticky flag for a resolve that had no outstanding branch to match
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_q <= 1'b0;
        end else if (resolveValid_i && empty) begin
            underflow_q <= 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (pop && !(&branch_cnt_q))
                branch_cnt_q <= branch_cnt_q + CNT_ONE;
            if (flush_now && !(&mispredict_cnt_q))
                mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
        end
    end

    assign update_o          = update_q;
    assign updateAddr_o      = update_addr_q;
    assign branchTaken_o     = branch_taken_q;
    assign mispredict_o      = mispredict_q;
    assign underflow_o       = underflow_q;
    assign branchCount_o     = branch_cnt_q;
    assign mispredictCount_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - directed self-checking bench for branch_resolution_unit
module tb_branch_resolution_unit;

    logic       clk;
    logic       rst_n;
    logic       predict_valid;
    logic [5:0] predict_addr;
    logic       prediction;
    logic       full;
    logic [2:0] occupancy;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       update;
    logic [5:0] update_addr;
    logic       branch_taken;
    logic       mispredict;
    logic       underflow;
    logic [3:0] branch_count;
    logic [3:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    logic [5:0] seq [8] = '{6'd0, 6'd9, 6'd18, 6'd27, 6'd36, 6'd45, 6'd54, 6'd63};

    branch_resolution_unit #(
        .ADDR_WIDTH  (6),
        .DEPTH       (4),
        .COUNT_WIDTH (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .predictValid_i    (predict_valid),
        .predictAddr_i     (predict_addr),
        .prediction_i      (prediction),
        .full_o            (full),
        .occupancy_o       (occupancy),
        .resolveValid_i    (resolve_valid),
        .resolveTaken_i    (resolve_taken),
        .update_o          (update),
        .updateAddr_o      (update_addr),
        .branchTaken_o     (branch_taken),
        .mispredict_o      (mispredict),
        .underflow_o       (underflow),
        .branchCount_o     (branch_count),
        .mispredictCount_o (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [5:0] a, input logic p);
        predict_valid = v;
        predict_addr  = a;
        prediction    = p;
    endtask

    task automatic set_resolve(input logic v, input logic t);
        resolve_valid = v;
        resolve_taken = t;
    endtask

    initial begin
        rst_n = 1'b0;
        set_push(1'b0, 6'd0, 1'b0);
        set_resolve(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_update", update, 0);
        check_eq("rst_uaddr", update_addr, 0);
        check_eq("rst_underflow", underflow, 0);
        check_eq("rst_bcnt", branch_count, 0);
        rst_n = 1'b1;
        step();

        // 1: single correct prediction
        set_push(1'b1, 6'd5, 1'b1);
        step();
        check_eq("t1_occ_after_push", occupancy, 1);
        set_push(1'b0, 6'd0, 1'b0);
        set_resolve(1'b1, 1'b1);
        step();
        set_resolve(1'b0, 1'b0);
        check_eq("t1_update", update, 1);
        check_eq("t1_uaddr", update_addr, 5);
        check_eq("t1_taken", branch_taken, 1);
        check_eq("t1_mispredict", mispredict, 0);
        check_eq("t1_bcnt", branch_count, 1);
        check_eq("t1_occ", occupancy, 0);
        step();
        check_eq("t1_update_pulse", update, 0);
        check_eq("t1_uaddr_hold", update_addr, 5);

        // 2: mispredict on the head flushes the queue and drops a same-cycle push
        set_push(1'b1, 6'd3, 1'b0); step();
        set_push(1'b1, 6'd7, 1'b1); step();
        set_push(1'b1, 6'd9, 1'b1); step();
        check_eq("t2_occ3", occupancy, 3);
        set_push(1'b1, 6'd10, 1'b1);
        set_resolve(1'b1, 1'b1);
        step();
        set_push(1'b0, 6'd0, 1'b0);
        set_resolve(1'b0, 1'b0);
        check_eq("t2_mispredict", mispredict, 1);
        check_eq("t2_update", update, 1);
        check_eq("t2_uaddr", update_addr, 3);
        check_eq("t2_occ", occupancy, 0);
        check_eq("t2_mcnt", mispredict_count, 1);
        check_eq("t2_bcnt", branch_count, 2);
        step();
        check_eq("t2_mispredict_pulse", mispredict, 0);

        // 3: fill to full, push with pop is dropped
        for (int i = 1; i <= 4; i++) begin
            set_push(1'b1, 6'(i), 1'b0);
            step();
        end
        check_eq("t3_full", full, 1);
        check_eq("t3_occ4", occupancy, 4);
        set_push(1'b1, 6'd6, 1'b0);
        set_resolve(1'b1, 1'b0);
        step();
        set_push(1'b0, 6'd0, 1'b0);
        check_eq("t3_occ_after", occupancy, 3);
        check_eq("t3_full_after", full, 0);
        check_eq("t3_uaddr1", update_addr, 1);
        check_eq("t3_mispredict", mispredict, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_eq("t3_drain_uaddr", update_addr, i);
            check_eq("t3_drain_update", update, 1);
        end
        set_resolve(1'b0, 1'b0);
        check_eq("t3_empty", occupancy, 0);
        check_eq("t3_bcnt", branch_count, 6);

        // 4: resolve while empty
        step();
        set_resolve(1'b1, 1'b1);
        step();
        set_resolve(1'b0, 1'b0);
        check_eq("t4_update", update, 0);
        check_eq("t4_underflow", underflow, 1);
        check_eq("t4_bcnt", branch_count, 6);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t4_underflow_hold", underflow, 1);
        end

        // 5: overlapped push/resolve through all indices, pointers wrap twice
        set_push(1'b1, seq[0], 1'b0);
        step();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) set_push(1'b1, seq[i], i[0]);
            else       set_push(1'b0, 6'd0, 1'b0);
            set_resolve(1'b1, ~i[0]);
            step();
            check_eq("t5_uaddr", update_addr, seq[i-1]);
            check_eq("t5_update", update, 1);
            check_eq("t5_mispredict", mispredict, 0);
            check_eq("t5_occ", occupancy, (i < 8) ? 1 : 0);
        end
        set_resolve(1'b0, 1'b0);
        check_eq("t5_bcnt", branch_count, 14);

        // 6: counters saturate at 15
        for (int i = 0; i < 20; i++) begin
            set_push(1'b1, 6'(i), 1'b0);
            step();
            set_push(1'b0, 6'd0, 1'b0);
            set_resolve(1'b1, 1'b1);
            step();
            set_resolve(1'b0, 1'b0);
        end
        check_eq("t6_mcnt_sat", mispredict_count, 15);
        check_eq("t6_bcnt_sat", branch_count, 15);

        // async reset with an update pulse pending and entries queued
        set_push(1'b1, 6'd11, 1'b1); step();
        set_push(1'b1, 6'd12, 1'b1); step();
        set_push(1'b0, 6'd0, 1'b0);
        set_resolve(1'b1, 1'b1);
        step();
        set_resolve(1'b0, 1'b0);
        check_eq("t7_pre_update", update, 1);
        check_eq("t7_pre_occ", occupancy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_update", update, 0);
        check_eq("t7_uaddr", update_addr, 0);
        check_eq("t7_taken", branch_taken, 0);
        check_eq("t7_occ", occupancy, 0);
        check_eq("t7_underflow", underflow, 0);
        check_eq("t7_mcnt", mispredict_count, 0);
        check_eq("t7_bcnt", branch_count, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("t7_post_occ", occupancy, 0);
        check_eq("t7_post_full", full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
